matmul_stream_ctrl: RTL and testbench

- Byte-serial front/back-end sequencer for the 10x10 8-bit matrix multiplier.
- Accepts A then B as a 200-byte valid/ready stream and packs them into the flattened 800-bit operand buses.
- Holds the multiplier in reset until both operands are loaded, releases it, waits for its done flag, then captures C.
- Streams C back out as 100 bytes with valid/ready and a last marker; sits between the host byte link and the multiplier.

---
 rtl/matmul_stream_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_matmul_stream_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_ctrl.sv
// matmul_stream_ctrl
// Byte-serial sequencer in front of / behind a 10x10 8-bit matrix multiplier.
// It packs A and then B (200 bytes) into the flattened operand buses. The
// multiplier is held in reset until both operands are loaded. The block then
// waits for mult_done, captures C, and streams it back out as N*N bytes.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, busy           job start (sampled in IDLE only), not-idle flag
//   in_data/valid/ready   operand byte stream (ready only in LOAD_A/LOAD_B)
//   out_data/valid/ready  result byte stream, out_last marks the final byte
//   job_done              one-cycle pulse after the final byte is accepted
//   err                   sticky WAIT timeout, cleared by the next start
//   mat_a, mat_b          flattened operands, element n at [n*W +: W]
//   mult_rst, mult_done   multiplier reset (active high) and done flag
//   mat_c                 flattened product from the multiplier
//
// Build option: define MATMUL_CTRL_CKSUM_EN to append one XOR checksum byte
// after C. That byte then carries out_last, and job_done follows it.
module matmul_stream_ctrl #(
  parameter int N        = 10,
  parameter int W        = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             job_done,
  output logic             err,
  output logic [N*N*W-1:0] mat_a,
  output logic [N*N*W-1:0] mat_b,
  output logic             mult_rst,
  input  logic             mult_done,
  input  logic [N*N*W-1:0] mat_c
);

  localparam int NE = N * N;
  localparam int CW = $clog2(NE);
  localparam int WC = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(NE - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [WC-1:0] WAIT_LAST = WC'(WAIT_MAX - 1);
  localparam logic [WC-1:0] WAIT_ONE  = WC'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_DRAIN  = 3'd4
`ifdef MATMUL_CTRL_CKSUM_EN
    , S_CKSUM = 3'd5
`endif
  } state_t;

`ifdef MATMUL_CTRL_CKSUM_EN
  function automatic logic [W-1:0] xor_bytes(input logic [N*N*W-1:0] v);
    logic [W-1:0] acc;
    acc = '0;
    for (int n = 0; n < NE; n++) begin
      acc = acc ^ v[n*W +: W];
    end
    return acc;
  endfunction
`endif

  state_t             state_r, state_n;
  logic [CW-1:0]      cnt_r, cnt_n;
  logic [WC-1:0]      wait_r, wait_n;
  logic [N*N*W-1:0]   c_buf_r, c_buf_n;
  logic               err_n, mult_rst_n, job_done_n;
  logic               load_a_s, load_b_s, capture_s;
  logic               busy_n, in_ready_n, out_valid_n, out_last_n;
  logic [W-1:0]       out_data_n;
  logic               in_acc_s, out_acc_s;

  // Handshakes: ready/valid are registered and only high in the owning states.
  assign in_acc_s  = in_valid & in_ready;
  assign out_acc_s = out_valid & out_ready;

  // Next-state, counters and control flags.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    wait_n     = wait_r;
    err_n      = err;
    mult_rst_n = mult_rst;
    job_done_n = 1'b0;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD_A;
          cnt_n   = '0;
          err_n   = 1'b0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOAD_A: begin
        if (in_acc_s) begin
          load_a_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_n = S_LOAD_B;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      S_LOAD_B: begin
        if (in_acc_s) begin
          load_b_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            // Operands complete: release the multiplier.
            state_n    = S_WAIT;
            cnt_n      = '0;
            mult_rst_n = 1'b0;
            wait_n     = '0;
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      S_WAIT: begin
        if (mult_done) begin
          capture_s  = 1'b1;
          mult_rst_n = 1'b1;
          cnt_n      = '0;
          state_n    = S_DRAIN;
        end else if (wait_r == WAIT_LAST) begin
          // WAIT_MAX cycles without done: abandon the job, no output.
          err_n      = 1'b1;
          mult_rst_n = 1'b1;
          state_n    = S_IDLE;
        end else begin
          wait_n = wait_r + WAIT_ONE;
        end
      end
      S_DRAIN: begin
        if (out_acc_s) begin
          if (cnt_r == CNT_LAST) begin
            cnt_n = '0;
`ifdef MATMUL_CTRL_CKSUM_EN
            state_n = S_CKSUM;
`else
            state_n    = S_IDLE;
            job_done_n = 1'b1;
`endif
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
`ifdef MATMUL_CTRL_CKSUM_EN
      S_CKSUM: begin
        if (out_acc_s) begin
          state_n    = S_IDLE;
          job_done_n = 1'b1;
        end else begin
          state_n = S_CKSUM;
        end
      end
`endif
      default: begin
        state_n    = S_IDLE;
        cnt_n      = '0;
        mult_rst_n = 1'b1;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state so that all
  // outputs leave the block straight from flops.
  always_comb begin
    c_buf_n     = capture_s ? mat_c : c_buf_r;
    busy_n      = 1'b1;
    in_ready_n  = 1'b0;
    out_valid_n = 1'b0;
    out_last_n  = 1'b0;
    out_data_n  = '0;
    case (state_n)
      S_IDLE: begin
        busy_n = 1'b0;
      end
      S_LOAD_A, S_LOAD_B: begin
        in_ready_n = 1'b1;
      end
      S_WAIT: begin
        in_ready_n = 1'b0;
      end
      S_DRAIN: begin
        out_valid_n = 1'b1;
        out_data_n  = c_buf_n[cnt_n*W +: W];
`ifdef MATMUL_CTRL_CKSUM_EN
        out_last_n  = 1'b0;
`else
        out_last_n  = (cnt_n == CNT_LAST);
`endif
      end
`ifdef MATMUL_CTRL_CKSUM_EN
      S_CKSUM: begin
        out_valid_n = 1'b1;
        out_last_n  = 1'b1;
        out_data_n  = xor_bytes(c_buf_n);
      end
`endif
      default: begin
        busy_n = 1'b1;
      end
    endcase
  end

  // State, counters, operand/result storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      wait_r    <= '0;
      c_buf_r   <= '0;
      mat_a     <= '0;
      mat_b     <= '0;
      err       <= 1'b0;
      mult_rst  <= 1'b1;
      job_done  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      wait_r    <= wait_n;
      c_buf_r   <= c_buf_n;
      err       <= err_n;
      mult_rst  <= mult_rst_n;
      job_done  <= job_done_n;
      busy      <= busy_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      out_data  <= out_data_n;
      if (load_a_s) mat_a[cnt_r*W +: W] <= in_data;
      if (load_b_s) mat_b[cnt_r*W +: W] <= in_data;
    end
  end

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// tb_matmul_stream_ctrl
// Randomized self-checking bench for matmul_stream_ctrl. A one-cycle
// multiplier stand-in drives mult_done/mat_c. Expected output bytes come from
// a matrix product computed over the bench's own operand arrays.
module tb_matmul_stream_ctrl;

  localparam int N  = 10;
  localparam int W  = 8;
  localparam int NE = N * N;

  logic            clk, rst_n, start, in_valid, out_ready, mult_done;
  logic [W-1:0]    in_data, out_data;
  logic            busy, in_ready, out_valid, out_last, job_done, err, mult_rst;
  logic [NE*W-1:0] mat_a, mat_b, mat_c;

  logic            done_r, done_en, done_force;
  logic [W-1:0]    a_m [NE];
  logic [W-1:0]    b_m [NE];
  int              n_checks, n_errors;

  matmul_stream_ctrl #(.N(N), .W(W), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .job_done(job_done), .err(err),
    .mat_a(mat_a), .mat_b(mat_b), .mult_rst(mult_rst),
    .mult_done(mult_done), .mat_c(mat_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stand-in: one cycle after reset release it presents C and done.
  function automatic logic [NE*W-1:0] mult_flat(input logic [NE*W-1:0] fa,
                                                input logic [NE*W-1:0] fb);
    logic [NE*W-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'(fa[(i*N+k)*W +: W]) * int'(fb[(k*N+j)*W +: W]);
        r[(i*N+j)*W +: W] = W'(s);
      end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      mat_c  <= '0;
    end else if (mult_rst || !done_en) begin
      done_r <= 1'b0;
    end else begin
      mat_c  <= mult_flat(mat_a, mat_b);
      done_r <= 1'b1;
    end
  end
  assign mult_done = done_r | done_force;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    check_value("rst_busy", busy, 0);
    check_value("rst_in_ready", in_ready, 0);
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_out_last", out_last, 0);
    check_value("rst_out_data", out_data, 0);
    check_value("rst_job_done", job_done, 0);
    check_value("rst_err", err, 0);
    check_value("rst_mult_rst", mult_rst, 1);
    check_value("rst_mat_a_zero", (mat_a == '0), 1);
    check_value("rst_mat_b_zero", (mat_b == '0), 1);
  endtask

  // Reference model: C[i][j] = low W bits of sum_k A[i][k]*B[k][j], in stream order.
  task automatic expected_stream(output logic [W-1:0] q[$]);
    logic [W-1:0] x;
    int s;
    q = {};
    x = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += int'(a_m[i*N+k]) * int'(b_m[k*N+j]);
        q.push_back(s % 256);
        x ^= W'(s % 256);
      end
`ifdef MATMUL_CTRL_CKSUM_EN
    q.push_back(x);
`endif
  endtask

  // mode 0: A=I, B[n]=n; 1: all 2; 2: all 0xFF; 3: random.
  task automatic run_job(input int mode, input bit stall, input bit gaps,
                         input bit done_ok, input int abort_after_b);
    logic [W-1:0] q[$];
    logic [W-1:0] prev_data;
    bit prev_stall, prev_last, acc;
    int cycles, guard, k, bad_a, bad_b;
    for (int n = 0; n < NE; n++) begin
      case (mode)
        0: begin a_m[n] = ((n / N) == (n % N)) ? 8'd1 : 8'd0; b_m[n] = W'(n); end
        1: begin a_m[n] = 8'd2; b_m[n] = 8'd2; end
        2: begin a_m[n] = 8'hFF; b_m[n] = 8'hFF; end
        default: begin a_m[n] = W'($urandom); b_m[n] = W'($urandom); end
      endcase
    end
    done_en = done_ok;
    // start together with a junk valid byte: the byte must not be consumed
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check_value("start_busy", busy, 1);
    check_value("start_in_ready", in_ready, 1);
    check_value("start_err_clear", err, 0);
    cycles = 0;
    for (int n = 0; n < 2*NE; n++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; in_data = W'($urandom);
          @(posedge clk); #1; cycles++;
        end
      end
      in_valid   = 1'b1;
      in_data    = (n < NE) ? a_m[n] : b_m[n-NE];
      done_force = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = 1'b0; guard = 0;
      while (!acc && guard < 20) begin
        acc = in_ready;
        @(posedge clk); #1; cycles++; guard++;
      end
      if (!acc) check_value("in_ready_timeout", 0, 1);
      if (abort_after_b >= 0 && n == NE + abort_after_b - 1) begin
        in_valid = 1'b0; done_force = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk) rst_n = 1'b1;
        return;
      end
    end
    in_valid = 1'b0; done_force = 1'b0;
    if (!gaps) check_value("load_cycles", cycles, 2*NE);
    bad_a = 0; bad_b = 0;
    for (int n = 0; n < NE; n++) begin
      if (mat_a[n*W +: W] !== a_m[n]) bad_a++;
      if (mat_b[n*W +: W] !== b_m[n]) bad_b++;
    end
    check_value("mat_a_bad_elems", bad_a, 0);
    check_value("mat_b_bad_elems", bad_b, 0);
    check_value("wait_in_ready", in_ready, 0);
    check_value("wait_mult_rst", mult_rst, 0);
    check_value("wait_out_valid", out_valid, 0);
    if (!done_ok) begin
      repeat (14) @(posedge clk);
      #1;
      check_value("to_err_early", err, 0);
      check_value("to_busy_early", busy, 1);
      @(posedge clk); #1;
      check_value("to_err", err, 1);
      check_value("to_mult_rst", mult_rst, 1);
      check_value("to_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check_value("to_err_sticky", err, 1);
      check_value("to_no_out_valid", out_valid, 0);
      return;
    end
    @(posedge clk); #1;
    check_value("lat_e1_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check_value("lat_e2_out_valid", out_valid, 1);
    check_value("lat_e2_mult_rst", mult_rst, 1);
    expected_stream(q);
    k = 0; guard = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (k < q.size() && guard < 2000) begin
      out_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      @(negedge clk);
      check_value("drain_out_valid", out_valid, 1);
      check_value("drain_job_done_low", job_done, 0);
      if (prev_stall) begin
        check_value("hold_data", out_data, prev_data);
        check_value("hold_last", out_last, prev_last);
      end
      if (out_ready) begin
        check_value($sformatf("out_byte_%0d", k), out_data, q[k]);
        check_value($sformatf("out_last_%0d", k), out_last, (k == q.size() - 1));
        k++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_data  = out_data;
        prev_last  = out_last;
      end
      @(posedge clk); #1; guard++;
    end
    out_ready = 1'b0;
    check_value("xfers", k, q.size());
    check_value("end_job_done", job_done, 1);
    check_value("end_out_valid", out_valid, 0);
    check_value("end_busy", busy, 0);
    check_value("end_err", err, 0);
    @(posedge clk); #1;
    check_value("job_done_pulse_end", job_done, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; done_en = 1'b1; done_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    @(negedge clk) rst_n = 1'b1;
    // valid bytes in IDLE are ignored
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    check_value("idle_in_ready", in_ready, 0);
    check_value("idle_mat_a", (mat_a == '0), 1);
    check_value("idle_busy", busy, 0);
    in_valid = 1'b0;

    run_job(0, 1'b0, 1'b0, 1'b1, -1);
    run_job(1, 1'b0, 1'b0, 1'b1, -1);
    run_job(2, 1'b0, 1'b0, 1'b1, -1);
    run_job(3, 1'b1, 1'b1, 1'b1, -1);
    run_job(3, 1'b0, 1'b1, 1'b0, -1);
    run_job(3, 1'b1, 1'b0, 1'b1, -1);
    run_job(0, 1'b0, 1'b0, 1'b1, 50);
    run_job(0, 1'b1, 1'b0, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
